// File: rtl/pd_pkg.sv
// Shared definitions for the RGB565 -> BFLOAT16 pixel sequencer.
//   chan_t      : channel tag carried on out_chan (R, G, B)
//   seq_state_t : sequencer state, naming the channel currently presented
//   *_MSB/*_LSB : RGB565 field positions inside a 16-bit pixel
package pd_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CH_R = 2'd1,
    ST_CH_G = 2'd2,
    ST_CH_B = 2'd3
  } seq_state_t;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

endpackage

// File: rtl/fp_lut6.sv
// Combinational 6-bit code to BFLOAT16 conversion.
// Returns the BFLOAT16 encoding of addr*4, so the full 0..63 code range
// maps onto 0.0 .. 252.0. Every result is exactly representable.
//   addr : 6-bit input code
//   data : BFLOAT16 value of addr*4 (16'h0000 for addr == 0)
module fp_lut6 (
  input  logic [5:0]  addr,
  output logic [15:0] data
);

  logic [2:0] msb;
  logic [6:0] mant;
  logic [7:0] expo;

  always_comb begin
    msb = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (addr[i]) msb = 3'(i);
    end
    // The leading one lands on bit 7 and falls off the 7-bit result,
    // leaving only the fraction bits left-aligned.
    mant = {1'b0, addr} << (3'd7 - msb);
    // Unbiased exponent is msb + 2 (the x4 scale), bias 127.
    expo = 8'd129 + {5'd0, msb};
    data = (addr == 6'd0) ? 16'h0000 : {1'b0, expo, mant};
  end

endmodule

// File: rtl/rgb565_bf16_sequencer.sv
// Streams RGB565 pixels out as three BFLOAT16 channel words (R, G, B)
// using one shared fp_lut6, with a per-frame pixel counter.
//   clk, reset_n     : clock, asynchronous active-low reset
//   clear            : synchronous flush of pending pixel and frame count
//   in_valid/in_ready/in_pixel : pixel input handshake
//   out_valid/out_ready/out_data/out_chan/out_last : channel word output
//   pix_count        : pixels accepted in the current frame
//
// state   | meaning
// IDLE    | nothing presented, ready for a pixel
// CH_R    | R word of the held pixel presented
// CH_G    | G word presented
// CH_B    | B word presented, next pixel may be accepted alongside
module rgb565_bf16_sequencer
  import pd_pkg::*;
#(
  parameter int FRAME_PIXELS = 784,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_pixel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic [1:0]       out_chan,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pix_count
);

  seq_state_t  state;
  // R is converted directly from in_pixel on accept, so only G and B are held.
  logic [10:0] pix_reg;
  logic        last_pix;
  logic [5:0]  lut_addr;
  logic [15:0] lut_data;
  logic        accept;
  logic        out_hs;
  logic        at_last;

  assign in_ready = !clear && (state == ST_IDLE || (state == ST_CH_B && out_ready));
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign at_last  = (pix_count == CNT_W'(FRAME_PIXELS - 1));

  always_comb begin
    lut_addr = 6'd0;
    if (accept)
      lut_addr = {in_pixel[R_MSB:R_LSB], 1'b0};
    else if (state == ST_CH_R)
      lut_addr = pix_reg[G_MSB:G_LSB];
    else if (state == ST_CH_G)
      lut_addr = {pix_reg[B_MSB:B_LSB], 1'b0};
  end

  fp_lut6 u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_chan  <= CH_R;
      out_last  <= 1'b0;
      pix_count <= '0;
      pix_reg   <= '0;
      last_pix  <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_chan  <= CH_R;
      out_last  <= 1'b0;
      pix_count <= '0;
      last_pix  <= 1'b0;
    end else begin
      if (accept) begin
        pix_reg   <= in_pixel[10:0];
        last_pix  <= at_last;
        pix_count <= at_last ? '0 : pix_count + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_CH_R;
            out_valid <= 1'b1;
            out_data  <= lut_data;
            out_chan  <= CH_R;
            out_last  <= 1'b0;
          end
        end
        ST_CH_R: begin
          if (out_hs) begin
            state    <= ST_CH_G;
            out_data <= lut_data;
            out_chan <= CH_G;
          end
        end
        ST_CH_G: begin
          if (out_hs) begin
            state    <= ST_CH_B;
            out_data <= lut_data;
            out_chan <= CH_B;
            out_last <= last_pix;
          end
        end
        ST_CH_B: begin
          if (accept) begin
            state     <= ST_CH_R;
            out_valid <= 1'b1;
            out_data  <= lut_data;
            out_chan  <= CH_R;
            out_last  <= 1'b0;
          end else if (out_hs) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_chan  <= CH_R;
            out_last  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_data  <= 16'h0000;
          out_chan  <= CH_R;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb565_bf16_sequencer.sv
module tb_rgb565_bf16_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_pixel;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        out_ready;
  logic [15:0] pix_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb565_bf16_sequencer #(.FRAME_PIXELS(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pix_count (pix_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] data, input logic [1:0] chan);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(data));
    chk({tag, "_chan"}, 32'(out_chan), 32'(chan));
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = 16'h0000;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_count", 32'(pix_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // single white pixel
    in_valid  = 1'b1;
    in_pixel  = 16'hFFFF;
    out_ready = 1'b1;
    #1;
    chk("w_inrdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_word("w_r", 16'h4378, 2'd0);
    chk("w_count", 32'(pix_count), 32'd1);
    tick();
    chk_word("w_g", 16'h437C, 2'd1);
    chk("w_inrdy_g", 32'(in_ready), 32'd0);
    tick();
    chk_word("w_b", 16'h4378, 2'd2);
    chk("w_inrdy_b", 32'(in_ready), 32'd1);
    chk("w_last", 32'(out_last), 32'd0);
    tick();
    chk("w_idle_valid", 32'(out_valid), 32'd0);
    chk("w_idle_data", 32'(out_data), 32'h0);

    // back-to-back 0821 then 0000
    in_valid = 1'b1;
    in_pixel = 16'h0821;
    tick();
    in_pixel = 16'h0000;
    chk_word("bb0_r", 16'h4100, 2'd0);
    tick();
    chk_word("bb0_g", 16'h4080, 2'd1);
    tick();
    chk_word("bb0_b", 16'h4100, 2'd2);
    chk("bb_inrdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_word("bb1_r", 16'h0000, 2'd0);
    chk("bb_count", 32'(pix_count), 32'd3);
    tick();
    chk_word("bb1_g", 16'h0000, 2'd1);
    tick();
    chk_word("bb1_b", 16'h0000, 2'd2);
    tick();
    chk("bb_idle", 32'(out_valid), 32'd0);

    // flush the frame count, then backpressure on the G word
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", 32'(pix_count), 32'd0);
    in_valid = 1'b1;
    in_pixel = 16'h0821;
    tick();
    chk_word("bp_r", 16'h4100, 2'd0);
    tick();
    out_ready = 1'b0;
    in_pixel  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      chk_word("bp_hold", 16'h4080, 2'd1);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk_word("bp_b", 16'h4100, 2'd2);
    chk("bp_count", 32'(pix_count), 32'd1);
    tick();
    chk("bp_idle", 32'(out_valid), 32'd0);

    // frame wrap with FRAME_PIXELS = 4, five pixels streamed
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_pixel = 16'h0821;
      tick();
      in_valid = 1'b0;
      chk_word("fr_r", 16'h4100, 2'd0);
      chk("fr_count", 32'(pix_count), (k == 3) ? 32'd0 : (k == 4) ? 32'd1 : 32'(k + 1));
      chk("fr_last_r", 32'(out_last), 32'd0);
      tick();
      chk("fr_last_g", 32'(out_last), 32'd0);
      tick();
      chk_word("fr_b", 16'h4100, 2'd2);
      chk("fr_last_b", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("fr_idle", 32'(out_valid), 32'd0);
    chk("fr_idle_last", 32'(out_last), 32'd0);

    // clear while G presented with a pixel offered
    in_valid = 1'b1;
    in_pixel = 16'h0821;
    tick();
    in_valid = 1'b0;
    tick();
    chk_word("cl_g", 16'h4080, 2'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_pixel = 16'hFFFF;
    #1;
    chk("cl_inrdy", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0;
    chk("cl_valid", 32'(out_valid), 32'd0);
    chk("cl_count", 32'(pix_count), 32'd0);
    chk("cl_data", 32'(out_data), 32'h0);
    in_pixel = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk_word("cl_next_r", 16'h0000, 2'd0);
    chk("cl_next_count", 32'(pix_count), 32'd1);
    tick();
    chk_word("cl_next_g", 16'h0000, 2'd1);
    tick();
    tick();

    // asynchronous reset mid-pixel
    in_valid = 1'b1;
    in_pixel = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    chk_word("ar_r", 16'h4378, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'h0);
    chk("ar_chan", 32'(out_chan), 32'd0);
    chk("ar_count", 32'(pix_count), 32'd0);
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_pixel = 16'h0821;
    tick();
    in_valid = 1'b0;
    chk_word("ar2_r", 16'h4100, 2'd0);
    tick();
    chk_word("ar2_g", 16'h4080, 2'd1);
    tick();
    chk_word("ar2_b", 16'h4100, 2'd2);
    chk("ar2_count", 32'(pix_count), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb565_bf16_sequencer.md
Name: rgb565_bf16_sequencer

Overview:
- Streams RGB565 pixels from the pixel buffer into the inference engine's first-layer input path as BFLOAT16 values.
- Time-multiplexes one shared fp_lut6 conversion instance across the R, G and B channels.
- Emits three channel words per pixel, in R, G, B order, over valid/ready handshakes.
- Counts pixels per frame and tags the final word of each frame.

Parameters:
- FRAME_PIXELS, 784, pixels per frame; out_last asserts on the B word of pixel FRAME_PIXELS-1.
- CNT_W, 16, width of the pixel counter. Must satisfy 2^CNT_W >= FRAME_PIXELS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops any pending pixel and zeroes the frame counter.
- in_valid  in  1  in_pixel is valid.
- in_pixel  in  16  RGB565 pixel: R=[15:11], G=[10:5], B=[4:0].
- in_ready  out  1  block accepts in_pixel this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  16  BFLOAT16 channel value.
- out_chan  out  2  channel tag: 0=R, 1=G, 2=B. Value 3 is never driven.
- out_last  out  1  last word of the frame.
- out_ready  in  1  downstream accepts the word this cycle.
- pix_count  out  CNT_W  number of pixels accepted in the current frame.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, out_valid=0, out_data=0, out_chan=0, out_last=0, pix_count=0, pixel register=0.
- State machine: IDLE, CH_R, CH_G, CH_B. The state names the channel currently presented on the output.
- LUT address mapping, with a single fp_lut6 instance whose address is muxed:
  - R: {R5, 1'b0}
  - G: G6
  - B: {B5, 1'b0}
  - Effect: 5-bit channels scale ×8 and the 6-bit channel ×4, so all channels land on the 0..252 range.
- in_ready = !clear && (state==IDLE || (state==CH_B && out_ready)). This is combinational, with no bubble between pixels.
- Accept (in_valid && in_ready):
  - in_pixel is captured into the pixel register.
  - The LUT is addressed from in_pixel's R field; its result is registered into out_data with out_chan=0.
  - Next state is CH_R. Latency is exactly 1 cycle from accept to out_valid.
- Output handshake (out_valid && out_ready):
  - CH_R -> CH_G: out_data=LUT(G), out_chan=1.
  - CH_G -> CH_B: out_data=LUT(B), out_chan=2.
  - CH_B -> CH_R if a new pixel is accepted in the same cycle, otherwise IDLE with out_valid=0.
- Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_last hold stable and no new pixel is accepted.
- Throughput: 1 pixel per 3 cycles with out_ready held high.
- Frame counter:
  - pix_count increments on each accept.
  - out_last=1 only while out_chan=2 and the presented pixel is index FRAME_PIXELS-1.
  - On the accept of that last pixel, pix_count wraps to 0. Wrap is at FRAME_PIXELS, not at 2^CNT_W.
- clear:
  - Next cycle: state=IDLE, out_valid=0, pix_count=0.
  - Overrides a simultaneous in_valid (pixel not accepted) and a simultaneous out handshake (remaining channels dropped).
- out_data is 16'h0000 whenever out_valid=0 after a flush or reset. The last value is not required to be held while idle.
- Illegal states are unreachable; default decoding returns to IDLE.

Decomposition:
- Shared package (pd_pkg):
  - channel-tag typedef/enum (CH_R=2'd0, CH_G=2'd1, CH_B=2'd2)
  - RGB565 field-index constants
  - sequencer state typedef
- Sub-module: reuse the existing fp_lut6 (one instance, combinational). Do not replicate it per channel.

Test Plan:
- Reset then single pixel 16'hFFFF, out_ready=1 -> words 16'h4378 (R, chan 0), 16'h437C (G, chan 1), 16'h4378 (B, chan 2) on cycles 1,2,3 after accept; in_ready high again with the B word.
- Pixel 16'h0821 then 16'h0000 back-to-back, out_ready=1 -> 4100, 4080, 4100, 0000, 0000, 0000 over 6 consecutive cycles, no idle cycle between pixels.
- Backpressure: out_ready low for 5 cycles while presenting the G word of 16'h0821 -> out_data holds 16'h4080 with chan 1, in_ready=0 throughout; resumes with 16'h4100.
- FRAME_PIXELS=4 override, 5 pixels streamed -> out_last=1 only on the B word of pixel 4; pix_count reads 0 after pixel 4's accept and 1 after pixel 5.
- clear asserted while CH_G is presented and in_valid=1 -> next cycle out_valid=0, pix_count=0, in_pixel not captured; the next pixel starts at chan 0.
- reset_n pulsed low mid-pixel (asynchronously, between edges) -> outputs go to reset values immediately; after release, a new pixel converts correctly.
